mode_ctrl: RTL and testbench
============================

# mode_ctrl

Processor mode and interrupt-entry controller that generates the 2-bit `Mode` consumed by the flags unit and register banking. Tracks boot/halt, user and interrupt-handler modes, latches interrupt requests, and enters the handler at instruction boundaries. Issues PC redirects for entry and return, and saves the return PC. Sits between the interrupt sources and the fetch stage; its `Mode` output directly selects the active flag set downstream.

## Interface
- `N_IRQ`, 4: number of interrupt lines (1..8).
- `PC_W`, 16: PC width.
- `VEC_BASE`, 16'h0010: address of vector 0.
- `VEC_STRIDE`, 4: byte/word spacing between vectors.

Ports (clock is `clk`; reset is `rst`, asynchronous, active-high):
- `clk` in 1: system clock.
- `rst` in 1: async reset, active-high.
- `start` in 1: leave boot mode.
- `halt` in 1: return to boot mode; highest priority.
- `irq` in N_IRQ: interrupt request lines, rising-edge sensitive.
- `instr_done` in 1: instruction retires this cycle; entry allowed.
- `pc_next` in PC_W: PC of next sequential instruction.
- `reti` in 1: return-from-interrupt retiring this cycle.
- `Mode` out 2: 00 boot/halt, 01 user, 10 handler; 11 never driven.
- `redirect` out 1: one-cycle fetch redirect pulse.
- `redirect_pc` out PC_W: target PC, valid with `redirect`.
- `irq_ack` out N_IRQ: one-hot, one-cycle ack of the serviced line.
- `epc` out PC_W: saved return PC.

## Operation
- States: BOOT, USER, DRAIN, ISR. `Mode` is 00 in BOOT, 01 in USER and DRAIN, 10 in ISR.
- Edge detection: `irq_q` holds the previous `irq`. A rising bit sets `pending[i]`.
- Service selection: lowest pending index wins.
- BOOT:
  - `start` -> USER.
  - `pending` is held at 0 and edges are ignored.
- USER:
  - `pending`≠0 and `instr_done` -> ISR, with entry action.
  - `pending`≠0 and no `instr_done` -> DRAIN.
- DRAIN:
  - Waits for `instr_done`, then -> ISR with entry action.
  - The winner is re-evaluated at the entry cycle.
- Entry action, registered at the edge:
  - `epc` <= `pc_next`.
  - `redirect`=1.
  - `redirect_pc` = VEC_BASE + idx*VEC_STRIDE, truncated to PC_W.
  - `irq_ack[idx]`=1.
  - `pending[idx]` cleared.
- ISR:
  - No nesting; new edges accumulate in `pending`.
  - `reti` with `pending`=0 -> USER; `redirect`=1, `redirect_pc`=`epc`.
  - `reti` with `pending`≠0 -> tail-chain: stay in ISR, redirect to the new vector, ack it, leave `epc` unchanged.
- `reti` outside ISR: ignored.
- `start` outside BOOT: ignored.
- `halt` in any state -> BOOT, clears `pending`, no redirect. This drives `Mode`=00, which clears the downstream flags.
- Simultaneous set and clear of the same pending bit: set wins, so the new edge is retained.

## Timing
- Reset values: `Mode`=00, `redirect`=0, `redirect_pc`=0, `irq_ack`=0, `epc`=0, `pending`=0, `irq_q`=0, state=BOOT.
- All outputs are registered.
- `irq` edge at cycle t -> `pending` set at t+1. Entry is possible on the first cycle t+1 or later with `instr_done`.
- Entry or return decision at edge e -> `Mode`, `redirect`, `redirect_pc`, `irq_ack` and `epc` all valid in the cycle after e. They change together on the same edge.
- `redirect` and `irq_ack` are single-cycle pulses and never back-to-back for one event.
- Reset mid-operation: immediate return to the reset values; pending requests are lost.

## Configuration
- `MODE_CTRL_MASK_EN` defined:
  - Adds inputs `mask_we` (1) and `mask_wdata` (N_IRQ).
  - Mask register resets to all-ones and is written on `mask_we`.
  - A masked line still latches into `pending` but is not eligible for selection.
  - Unmasking a pending line makes it eligible the next cycle.
- `MODE_CTRL_MASK_EN` undefined: no mask ports or mask register; all lines are always eligible.

## Structure
- Shared package `mode_pkg`:
  - Mode encoding constants MODE_BOOT=2'b00, MODE_USER=2'b01, MODE_ISR=2'b10.
  - State enum.
  - Default VEC_BASE/VEC_STRIDE.
- Sub-module `irq_pending`: edge detect, pending register, optional mask, lowest-index priority encoder. Outputs `any` and `idx`, and takes a clear one-hot input.

## Test plan
- Reset, then `start` -> `Mode` goes 00->01 the next cycle. `irq[2]` edge with `instr_done`=1, `pc_next`=16'h0040 -> the next cycle shows `Mode`=10, `redirect`=1, `redirect_pc`=16'h0018, `irq_ack`=0100, `epc`=16'h0040.
- `irq[1]` and `irq[3]` edges in the same cycle -> line 1 serviced first. A `reti` then tail-chains to vector 16'h001C with `Mode` staying 10 and `epc` unchanged. The final `reti` returns to `epc` with `Mode`=01.
- Pending request with `instr_done` held low for 5 cycles -> `Mode` stays 01, no redirect. Entry occurs in the cycle after `instr_done` rises.
- `halt` during ISR with a pending bit set -> `Mode`=00 the next cycle, `pending`=0, no redirect. `irq` edges in BOOT are ignored after `start`.
- `rst` asserted mid-ISR -> all outputs immediately return to their reset values. `reti` in USER produces no redirect.
- With `MODE_CTRL_MASK_EN`: mask=1110 and an `irq[0]` edge -> no entry. Writing mask=1111 -> entry to 16'h0010 within 2 cycles.

Source files
------------

// File: rtl/mode_pkg.sv
// mode_pkg: mode encodings, controller state enum and default vector layout
// shared by mode_ctrl and irq_pending.
package mode_pkg;
   localparam logic [1:0] MODE_BOOT = 2'b00;
   localparam logic [1:0] MODE_USER = 2'b01;
   localparam logic [1:0] MODE_ISR  = 2'b10;
   localparam int DEF_VEC_BASE   = 'h10;
   localparam int DEF_VEC_STRIDE = 4;
   typedef enum logic [1:0] {S_BOOT, S_USER, S_DRAIN, S_ISR} state_e;
   function automatic logic [1:0] mode_of(state_e s);
      return (s == S_ISR) ? MODE_ISR : (s == S_BOOT) ? MODE_BOOT : MODE_USER;
   endfunction
endpackage

// File: rtl/irq_pending.sv
// irq_pending: rising-edge capture of irq lines into a pending register plus
// lowest-index selection; MODE_CTRL_MASK_EN adds a writable eligibility mask.
module irq_pending
   import mode_pkg::*;
#(
   parameter int N_IRQ = 4,
   localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic             clr_all_i,
   input  logic [N_IRQ-1:0] clr_i,
`ifdef MODE_CTRL_MASK_EN
   input  logic             mask_we_i,
   input  logic [N_IRQ-1:0] mask_wdata_i,
`endif
   output logic             any_o,
   output logic [IW-1:0]    idx_o
);
   logic [N_IRQ-1:0] irq_q, pending_q, pending_d, mask, elig;
`ifdef MODE_CTRL_MASK_EN
   logic [N_IRQ-1:0] mask_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) mask_q <= '1;
      else if (mask_we_i) mask_q <= mask_wdata_i;
   assign mask = mask_q;
`else
   assign mask = '1;
`endif
   // a new edge beats a simultaneous service clear of the same bit
   assign pending_d = clr_all_i ? '0 : (pending_q & ~clr_i) | (irq_i & ~irq_q);
   assign elig = pending_q & mask;
   assign any_o = |elig;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         irq_q     <= '0;
         pending_q <= '0;
      end else begin
         irq_q     <= irq_i;
         pending_q <= pending_d;
      end
   always_comb begin
      idx_o = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (elig[i]) idx_o = IW'(i);
   end
endmodule

// File: rtl/mode_ctrl.sv
// mode_ctrl: processor mode / interrupt-entry FSM driving Mode, fetch redirects,
// irq acks and the saved return PC. Optional mask via MODE_CTRL_MASK_EN.
module mode_ctrl
   import mode_pkg::*;
#(
   parameter int N_IRQ      = 4,
   parameter int PC_W       = 16,
   parameter int VEC_BASE   = DEF_VEC_BASE,
   parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic [N_IRQ-1:0] irq,
   input  logic             instr_done,
   input  logic [PC_W-1:0]  pc_next,
   input  logic             reti,
`ifdef MODE_CTRL_MASK_EN
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
`endif
   output logic [1:0]       Mode,
   output logic             redirect,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [N_IRQ-1:0] irq_ack,
   output logic [PC_W-1:0]  epc
);
   localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   state_e state_q, state_d;
   logic [1:0] mode_q;
   logic redirect_q, redirect_d, any, entry;
   logic [PC_W-1:0] rpc_q, rpc_d, epc_q, epc_d;
   logic [N_IRQ-1:0] ack_q, ack_d, clr, onehot;
   logic [IW-1:0] idx;
   irq_pending #(.N_IRQ(N_IRQ)) u_pend (
      .clk          (clk),
      .rst          (rst),
      .irq_i        (irq),
      .clr_all_i    (halt || state_q == S_BOOT),
      .clr_i        (clr),
`ifdef MODE_CTRL_MASK_EN
      .mask_we_i    (mask_we),
      .mask_wdata_i (mask_wdata),
`endif
      .any_o        (any),
      .idx_o        (idx)
   );
   assign onehot = N_IRQ'(1) << idx;
   always_comb begin
      state_d    = state_q;
      redirect_d = 1'b0;
      rpc_d      = rpc_q;
      epc_d      = epc_q;
      ack_d      = '0;
      clr        = '0;
      entry      = 1'b0;
      if (halt) state_d = S_BOOT;
      else
         case (state_q)
            S_BOOT:  if (start) state_d = S_USER;
            S_USER:  if (any) begin
                        entry   = instr_done;
                        state_d = S_DRAIN;
                     end
            S_DRAIN: if (!any) state_d = S_USER;
                     else entry = instr_done;
            S_ISR:   if (reti) begin
                        entry = any;
                        if (!any) begin
                           state_d    = S_USER;
                           redirect_d = 1'b1;
                           rpc_d      = epc_q;
                        end
                     end
            default: state_d = S_BOOT;
         endcase
      // tail-chaining from ISR keeps the original return PC
      if (entry) begin
         state_d    = S_ISR;
         redirect_d = 1'b1;
         rpc_d      = PC_W'(VEC_BASE + VEC_STRIDE * int'(idx));
         ack_d      = onehot;
         clr        = onehot;
         epc_d      = (state_q == S_ISR) ? epc_q : pc_next;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= S_BOOT;
         mode_q     <= MODE_BOOT;
         redirect_q <= 1'b0;
         rpc_q      <= '0;
         ack_q      <= '0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_of(state_d);
         redirect_q <= redirect_d;
         rpc_q      <= rpc_d;
         ack_q      <= ack_d;
         epc_q      <= epc_d;
      end
   assign Mode        = mode_q;
   assign redirect    = redirect_q;
   assign redirect_pc = rpc_q;
   assign irq_ack     = ack_q;
   assign epc         = epc_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// tb_mode_ctrl: directed, hand-computed checks of mode_ctrl entry, tail-chain,
// drain, halt and reset behaviour (mask section only with MODE_CTRL_MASK_EN).
module tb_mode_ctrl;
   logic clk = 0, rst = 1, start = 0, halt = 0, instr_done = 0, reti = 0;
   logic [3:0] irq = '0;
   logic [15:0] pc_next = '0;
   logic [1:0] Mode;
   logic redirect;
   logic [15:0] redirect_pc, epc;
   logic [3:0] irq_ack;
`ifdef MODE_CTRL_MASK_EN
   logic mask_we = 0;
   logic [3:0] mask_wdata = '1;
`endif
   int n_cmp = 0, n_err = 0;
   mode_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .irq(irq),
      .instr_done(instr_done), .pc_next(pc_next), .reti(reti),
`ifdef MODE_CTRL_MASK_EN
      .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
      .Mode(Mode), .redirect(redirect), .redirect_pc(redirect_pc),
      .irq_ack(irq_ack), .epc(epc)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic all_out(input string tag, input logic [1:0] m, input logic r,
                          input logic [15:0] rp, input logic [3:0] a, input logic [15:0] e);
      chk({tag, ".mode"}, 32'(Mode), 32'(m));
      chk({tag, ".redirect"}, 32'(redirect), 32'(r));
      chk({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(rp));
      chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(a));
      chk({tag, ".epc"}, 32'(epc), 32'(e));
   endtask
   initial begin
      tick();
      all_out("reset_held", 2'b00, 0, 16'h0, 4'h0, 16'h0);
      tick();
      rst = 0;
      tick();
      all_out("after_reset", 2'b00, 0, 16'h0, 4'h0, 16'h0);
      // boot -> user
      start = 1; tick(); start = 0;
      chk("start_mode", 32'(Mode), 32'h1);
      // irq[2] entry
      irq = 4'b0100; instr_done = 1; pc_next = 16'h0040; tick();
      chk("irq2_latch_mode", 32'(Mode), 32'h1);
      chk("irq2_latch_redirect", 32'(redirect), 32'h0);
      tick();
      all_out("irq2_entry", 2'b10, 1, 16'h0018, 4'b0100, 16'h0040);
      tick();
      chk("irq2_pulse_redirect", 32'(redirect), 32'h0);
      chk("irq2_pulse_ack", 32'(irq_ack), 32'h0);
      chk("irq2_isr_mode", 32'(Mode), 32'h2);
      reti = 1; tick(); reti = 0;
      all_out("irq2_return", 2'b01, 1, 16'h0040, 4'b0000, 16'h0040);
      // simultaneous irq[1] and irq[3]: lowest first, then tail-chain
      irq = 4'b0000; tick();
      irq = 4'b1010; pc_next = 16'h0080; tick();
      tick();
      all_out("irq1_entry", 2'b10, 1, 16'h0014, 4'b0010, 16'h0080);
      reti = 1; pc_next = 16'h0099; tick(); reti = 0;
      all_out("tail_chain", 2'b10, 1, 16'h001C, 4'b1000, 16'h0080);
      tick();
      chk("tail_chain_pulse", 32'(redirect), 32'h0);
      reti = 1; tick(); reti = 0;
      all_out("final_return", 2'b01, 1, 16'h0080, 4'b0000, 16'h0080);
      // drain: request waits for instr_done
      irq = 4'b0000; instr_done = 0; tick();
      irq = 4'b0001; tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("drain_mode", 32'(Mode), 32'h1);
         chk("drain_redirect", 32'(redirect), 32'h0);
      end
      instr_done = 1; pc_next = 16'h0100; tick();
      all_out("drain_entry", 2'b10, 1, 16'h0010, 4'b0001, 16'h0100);
      // halt in ISR with a pending bit
      irq = 4'b0000; tick();
      irq = 4'b0100; tick();
      tick();
      chk("isr_no_nest_mode", 32'(Mode), 32'h2);
      chk("isr_no_nest_redirect", 32'(redirect), 32'h0);
      halt = 1; tick(); halt = 0;
      chk("halt_mode", 32'(Mode), 32'h0);
      chk("halt_redirect", 32'(redirect), 32'h0);
      chk("halt_ack", 32'(irq_ack), 32'h0);
      irq = 4'b0000; tick();
      irq = 4'b0010; tick();
      tick();
      start = 1; tick(); start = 0;
      chk("restart_mode", 32'(Mode), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("boot_edges_ignored_mode", 32'(Mode), 32'h1);
         chk("boot_edges_ignored_redirect", 32'(redirect), 32'h0);
      end
      // reti and start in USER are ignored
      reti = 1; start = 1; tick(); reti = 0; start = 0;
      chk("reti_user_redirect", 32'(redirect), 32'h0);
      chk("reti_user_mode", 32'(Mode), 32'h1);
`ifdef MODE_CTRL_MASK_EN
      irq = 4'b0000; mask_we = 1; mask_wdata = 4'b1110; tick(); mask_we = 0;
      irq = 4'b0001; tick();
      tick(); tick();
      chk("masked_mode", 32'(Mode), 32'h1);
      chk("masked_redirect", 32'(redirect), 32'h0);
      mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
      tick();
      all_out("unmask_entry", 2'b10, 1, 16'h0010, 4'b0001, 16'h0100);
      reti = 1; tick(); reti = 0;
      chk("unmask_return", 32'(Mode), 32'h1);
`endif
      // async reset mid-ISR
      irq = 4'b0000; tick();
      irq = 4'b1000; pc_next = 16'h0200; tick();
      tick();
      all_out("irq3_entry", 2'b10, 1, 16'h001C, 4'b1000, 16'h0200);
      #2 rst = 1; #1;
      all_out("async_reset", 2'b00, 0, 16'h0, 4'h0, 16'h0);
      tick(); rst = 0;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_reset_lost_mode", 32'(Mode), 32'h1);
         chk("post_reset_lost_redirect", 32'(redirect), 32'h0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
